// File: rtl/sprite_scheduler.sv
// Frame-level sequencer for the stream-processor array: walks the sprite table in index order,
// fetches each valid sprite's texture and broadcasts it to the processors with a one-cycle enable.
module sprite_scheduler #(
  parameter int unsigned N_SPRITES  = 8,
  parameter int unsigned IDX_W      = 3,
  parameter int unsigned TEX_ADDR_W = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic                  cfg_valid,
  input  logic [3:0]            cfg_start_x,
  input  logic [7:0]            cfg_z,
  input  logic [TEX_ADDR_W-1:0] cfg_tex,
  input  logic                  frame_start,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  tex_req,
  output logic [TEX_ADDR_W-1:0] tex_addr,
  input  logic                  tex_ack,
  input  logic [2047:0]         tex_data,
  output logic                  sp_clear_n,
  output logic                  sp_ena,
  output logic [2047:0]         sp_texture_data,
  output logic [3:0]            sp_start_x,
  output logic [7:0]            sp_position_z
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StScan,
    StFetch,
    StIssue,
    StDone
  } state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_SPRITES - 1);

  state_e                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [N_SPRITES-1:0]  tbl_valid_q;
  logic [3:0]            tbl_x_q   [N_SPRITES];
  logic [7:0]            tbl_z_q   [N_SPRITES];
  logic [TEX_ADDR_W-1:0] tbl_tex_q [N_SPRITES];

  // Host writes are only taken while idle so a frame always sees a consistent table.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tbl_valid_q <= '0;
      for (int i = 0; i < N_SPRITES; i++) begin
        tbl_x_q[i]   <= '0;
        tbl_z_q[i]   <= '0;
        tbl_tex_q[i] <= '0;
      end
    end else if (cfg_we && !busy) begin
      tbl_valid_q[cfg_idx] <= cfg_valid;
      tbl_x_q[cfg_idx]     <= cfg_start_x;
      tbl_z_q[cfg_idx]     <= cfg_z;
      tbl_tex_q[cfg_idx]   <= cfg_tex;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      idx_q           <= '0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      tex_req         <= 1'b0;
      tex_addr        <= '0;
      sp_clear_n      <= 1'b1;
      sp_ena          <= 1'b0;
      sp_texture_data <= '0;
      sp_start_x      <= '0;
      sp_position_z   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (frame_start) begin
            busy       <= 1'b1;
            sp_clear_n <= 1'b0;
            state_q    <= StClear;
          end
        end
        StClear: begin
          sp_clear_n <= 1'b1;
          idx_q      <= '0;
          state_q    <= StScan;
        end
        StScan: begin
          if (tbl_valid_q[idx_q]) begin
            tex_addr <= tbl_tex_q[idx_q];
            tex_req  <= 1'b1;
            state_q  <= StFetch;
          end else if (idx_q == LastIdx) begin
            frame_done <= 1'b1;
            state_q    <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StFetch: begin
          // Bus is loaded on the ack edge so it is already valid when sp_ena rises.
          if (tex_ack) begin
            sp_texture_data <= tex_data;
            sp_start_x      <= tbl_x_q[idx_q];
            sp_position_z   <= tbl_z_q[idx_q];
            tex_req         <= 1'b0;
            sp_ena          <= 1'b1;
            state_q         <= StIssue;
          end
        end
        StIssue: begin
          sp_ena <= 1'b0;
          if (idx_q == LastIdx) begin
            frame_done <= 1'b1;
            state_q    <= StDone;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= StScan;
          end
        end
        StDone: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Self-checking bench for sprite_scheduler: table of frame scenarios plus hand-written
// sequences for simultaneous write/start, reset during fetch and spurious acknowledges.
module tb_sprite_scheduler;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_idx = '0;
  logic          cfg_valid = 1'b0;
  logic [3:0]    cfg_start_x = '0;
  logic [7:0]    cfg_z = '0;
  logic [5:0]    cfg_tex = '0;
  logic          frame_start = 1'b0;
  logic          busy;
  logic          frame_done;
  logic          tex_req;
  logic [5:0]    tex_addr;
  logic          tex_ack = 1'b0;
  logic [2047:0] tex_data = '0;
  logic          sp_clear_n;
  logic          sp_ena;
  logic [2047:0] sp_texture_data;
  logic [3:0]    sp_start_x;
  logic [7:0]    sp_position_z;

  sprite_scheduler #(
    .N_SPRITES (8),
    .IDX_W     (3),
    .TEX_ADDR_W(6)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_we         (cfg_we),
    .cfg_idx        (cfg_idx),
    .cfg_valid      (cfg_valid),
    .cfg_start_x    (cfg_start_x),
    .cfg_z          (cfg_z),
    .cfg_tex        (cfg_tex),
    .frame_start    (frame_start),
    .busy           (busy),
    .frame_done     (frame_done),
    .tex_req        (tex_req),
    .tex_addr       (tex_addr),
    .tex_ack        (tex_ack),
    .tex_data       (tex_data),
    .sp_clear_n     (sp_clear_n),
    .sp_ena         (sp_ena),
    .sp_texture_data(sp_texture_data),
    .sp_start_x     (sp_start_x),
    .sp_position_z  (sp_position_z)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int frame_no = 0;

  // Expected descriptor table.
  logic       m_valid [N];
  logic [3:0] m_sx    [N];
  logic [7:0] m_z     [N];
  logic [5:0] m_tex   [N];

  typedef struct {
    logic [7:0] mask;
    logic [3:0] sx_base;
    logic [7:0] z_base;
    logic [7:0] z_step;
    logic [5:0] tex_base;
    int         delay;
    int         exp_done;
    bit         keep;
    bit         mid_wr;
    bit         dbl_start;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_wide(input string nm, input logic [2047:0] act, input logic [2047:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got ..%0h expected ..%0h (low 64 bits)", nm, act[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [2047:0] pat(input logic [5:0] a, input int f);
    logic [7:0] b;
    b = 8'(a * 11 + f * 3 + 1);
    return {{255{b}}, ~b};
  endfunction

  task automatic write_cfg(input int slot, input logic v, input logic [3:0] sx,
                           input logic [7:0] z, input logic [5:0] tx);
    cfg_we = 1'b1;
    cfg_idx = 3'(slot);
    cfg_valid = v;
    cfg_start_x = sx;
    cfg_z = z;
    cfg_tex = tx;
    @(negedge clk);
    cfg_we = 1'b0;
    m_valid[slot] = v;
    m_sx[slot] = sx;
    m_z[slot] = z;
    m_tex[slot] = tx;
  endtask

  // Starts a frame at a negedge and follows it cycle by cycle (k = cycles after edge T).
  task automatic run_frame(input string nm, input int delay, input int exp_done,
                           input bit mid_wr, input bit dbl_start, input bit co_wr);
    int done_at = 0;
    int done_cnt = 0;
    int issues = 0;
    int exp_issues = 0;
    int wait_cnt = 0;
    int nxt = 0;
    int exp_slot = -1;
    int clr_extra = 0;
    int unexpected = 0;
    bit in_fetch = 0;
    bit busy_gap = 0;
    bit dbl_ena = 0;
    bit prev_ena = 0;
    bit addr_moved = 0;
    logic [5:0] held = '0;
    logic [2047:0] acked = '0;
    frame_no++;
    if (co_wr) begin
      cfg_we = 1'b1;
      cfg_idx = 3'd5;
      cfg_valid = 1'b1;
      cfg_start_x = 4'd9;
      cfg_z = 8'd77;
      cfg_tex = 6'd33;
      m_valid[5] = 1'b1;
      m_sx[5] = 4'd9;
      m_z[5] = 8'd77;
      m_tex[5] = 6'd33;
    end
    for (int v = 0; v < N; v++) if (m_valid[v]) exp_issues++;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    cfg_we = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      tex_ack = 1'b0;
      tex_data = {256{8'hA5}};
      if (k == 1) chk({nm, " clear_at_T+1"}, 64'(sp_clear_n), 64'd0);
      else if (!sp_clear_n) clr_extra++;
      if (done_at == 0 && !busy) busy_gap = 1;
      if (tex_req) begin
        if (!in_fetch) begin
          in_fetch = 1;
          wait_cnt = 0;
          held = tex_addr;
          exp_slot = -1;
          for (int j = nxt; j < N; j++) if (m_valid[j] && exp_slot < 0) exp_slot = j;
          if (exp_slot < 0) unexpected++;
          else chk({nm, " tex_addr"}, 64'(tex_addr), 64'(m_tex[exp_slot]));
        end else if (tex_addr !== held) begin
          addr_moved = 1;
        end
        wait_cnt++;
        if (wait_cnt == delay) begin
          acked = pat(tex_addr, frame_no);
          tex_data = acked;
          tex_ack = 1'b1;
        end
      end else begin
        in_fetch = 0;
      end
      if (sp_ena) begin
        issues++;
        if (prev_ena) dbl_ena = 1;
        if (exp_slot >= 0) begin
          chk({nm, " sp_start_x"}, 64'(sp_start_x), 64'(m_sx[exp_slot]));
          chk({nm, " sp_position_z"}, 64'(sp_position_z), 64'(m_z[exp_slot]));
          chk_wide({nm, " sp_texture_data"}, sp_texture_data, acked);
          nxt = exp_slot + 1;
          exp_slot = -1;
        end
      end
      prev_ena = sp_ena;
      if (frame_done) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
      if (done_at != 0 && k == done_at + 1) chk({nm, " busy_after_done"}, 64'(busy), 64'd0);
      if (done_at != 0 && k >= done_at + 4) break;
      if (mid_wr && k == 3) begin
        cfg_we = 1'b1;
        cfg_idx = 3'd0;
        cfg_valid = 1'b1;
        cfg_start_x = 4'd15;
        cfg_z = 8'd255;
        cfg_tex = 6'd63;
      end
      if (k == 4) cfg_we = 1'b0;
      if (dbl_start && k == 4) frame_start = 1'b1;
      if (k == 5) frame_start = 1'b0;
      @(negedge clk);
    end
    tex_ack = 1'b0;
    cfg_we = 1'b0;
    frame_start = 1'b0;
    chk({nm, " frame_done_cycle"}, 64'(done_at), 64'(exp_done));
    chk({nm, " frame_done_count"}, 64'(done_cnt), 64'd1);
    chk({nm, " issue_count"}, 64'(issues), 64'(exp_issues));
    chk({nm, " busy_gap"}, 64'(busy_gap), 64'd0);
    chk({nm, " extra_clear"}, 64'(clr_extra), 64'd0);
    chk({nm, " addr_moved"}, 64'(addr_moved), 64'd0);
    chk({nm, " ena_back_to_back"}, 64'(dbl_ena), 64'd0);
    chk({nm, " unexpected_req"}, 64'(unexpected), 64'd0);
  endtask

  initial begin
    vecs[0] = '{mask: 8'h00, sx_base: 4'd0, z_base: 8'd0, z_step: 8'd0, tex_base: 6'd0,
                delay: 1, exp_done: 10, keep: 0, mid_wr: 1, dbl_start: 0};
    vecs[1] = '{mask: 8'h00, sx_base: 4'd0, z_base: 8'd0, z_step: 8'd0, tex_base: 6'd0,
                delay: 1, exp_done: 10, keep: 1, mid_wr: 0, dbl_start: 0};
    vecs[2] = '{mask: 8'h08, sx_base: 4'd15, z_base: 8'd37, z_step: 8'd1, tex_base: 6'd2,
                delay: 1, exp_done: 12, keep: 0, mid_wr: 0, dbl_start: 0};
    vecs[3] = '{mask: 8'h42, sx_base: 4'd4, z_base: 8'd20, z_step: 8'd5, tex_base: 6'd10,
                delay: 3, exp_done: 18, keep: 0, mid_wr: 0, dbl_start: 0};
    vecs[4] = '{mask: 8'h14, sx_base: 4'd1, z_base: 8'd10, z_step: 8'd0, tex_base: 6'd20,
                delay: 2, exp_done: 16, keep: 0, mid_wr: 0, dbl_start: 0};
    vecs[5] = '{mask: 8'hFF, sx_base: 4'd0, z_base: 8'd100, z_step: 8'd3, tex_base: 6'd40,
                delay: 1, exp_done: 26, keep: 0, mid_wr: 0, dbl_start: 1};
    vecs[6] = '{mask: 8'h81, sx_base: 4'd7, z_base: 8'd200, z_step: 8'd1, tex_base: 6'd60,
                delay: 5, exp_done: 22, keep: 0, mid_wr: 1, dbl_start: 0};
    for (int s = 0; s < N; s++) begin
      m_valid[s] = 1'b0;
      m_sx[s] = '0;
      m_z[s] = '0;
      m_tex[s] = '0;
    end

    #2 reset_n = 1'b0;
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset frame_done", 64'(frame_done), 64'd0);
    chk("reset tex_req", 64'(tex_req), 64'd0);
    chk("reset sp_ena", 64'(sp_ena), 64'd0);
    chk("reset sp_clear_n", 64'(sp_clear_n), 64'd1);
    chk("reset tex_addr", 64'(tex_addr), 64'd0);
    chk_wide("reset sp_texture_data", sp_texture_data, '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      if (!vecs[i].keep) begin
        for (int s = 0; s < N; s++) begin
          write_cfg(s, vecs[i].mask[s], 4'(vecs[i].sx_base + 4'(s)),
                    8'(vecs[i].z_base + vecs[i].z_step * 8'(s)), 6'(vecs[i].tex_base + 6'(s)));
        end
      end
      run_frame($sformatf("v%0d", i), vecs[i].delay, vecs[i].exp_done, vecs[i].mid_wr,
                vecs[i].dbl_start, 1'b0);
    end

    // Descriptor write in the same idle cycle as frame_start is used by that frame.
    for (int s = 0; s < N; s++) write_cfg(s, 1'b0, 4'd0, 8'd0, 6'd0);
    run_frame("co_write", 1, 12, 1'b0, 1'b0, 1'b1);

    // Reset while waiting for an acknowledge.
    for (int s = 0; s < N; s++) write_cfg(s, 1'b0, 4'd0, 8'd0, 6'd0);
    write_cfg(2, 1'b1, 4'd6, 8'd50, 6'd17);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int k = 0; k < 20 && !tex_req; k++) @(negedge clk);
    chk("rst tex_req_seen", 64'(tex_req), 64'd1);
    repeat (2) @(negedge clk);
    chk("rst still_waiting", 64'(tex_req), 64'd1);
    chk("rst tex_addr_before", 64'(tex_addr), 64'd17);
    #2 reset_n = 1'b0;
    #1;
    chk("rst async busy", 64'(busy), 64'd0);
    chk("rst async tex_req", 64'(tex_req), 64'd0);
    chk("rst async frame_done", 64'(frame_done), 64'd0);
    chk("rst async sp_ena", 64'(sp_ena), 64'd0);
    chk("rst async sp_clear_n", 64'(sp_clear_n), 64'd1);
    chk("rst async tex_addr", 64'(tex_addr), 64'd0);
    chk("rst async sp_start_x", 64'(sp_start_x), 64'd0);
    chk("rst async sp_position_z", 64'(sp_position_z), 64'd0);
    chk_wide("rst async sp_texture_data", sp_texture_data, '0);
    @(negedge clk);
    chk("rst held frame_done", 64'(frame_done), 64'd0);
    reset_n = 1'b1;
    for (int s = 0; s < N; s++) m_valid[s] = 1'b0;
    @(negedge clk);

    // Acknowledge pulsed while idle must not load the broadcast bus.
    tex_ack = 1'b1;
    tex_data = pat(6'd9, 99);
    @(negedge clk);
    tex_ack = 1'b0;
    chk_wide("spurious_ack sp_texture_data", sp_texture_data, '0);
    chk("spurious_ack sp_ena", 64'(sp_ena), 64'd0);
    chk("spurious_ack busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("spurious_ack sp_ena_late", 64'(sp_ena), 64'd0);

    // Valid bits cleared by reset: an empty frame follows.
    run_frame("after_reset", 1, 10, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
